pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the five-stage RISC-V pipeline. It drives the stall and flush controls of the F/D, D/E, E/M and M/W pipeline registers, and the E-stage forwarding mux selects. It owns a small FSM that freezes the pipeline while the data memory withholds its ready handshake, and it declares a sticky error on timeout. Saturating stall and flush event counters provide performance visibility.

---
 rtl/hazard_pkg.sv | 7 +
 rtl/forward_sel.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 94 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state and forwarding-select encodings for the hazard controller
package hazard_pkg;
    typedef enum logic [1:0] {RUN, WAIT, ERROR} state_t;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/forward_sel.sv
// forward_sel: E-stage operand bypass select, Memory stage wins over Writeback
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] ForwardE
);
    logic w_hit_m;
    logic w_hit_w;
    always_comb begin
        w_hit_m  = RegWriteM && (RdM != 5'd0) && (RdM == RsE);
        w_hit_w  = RegWriteW && (RdW != 5'd0) && (RdW == RsE);
        ForwardE = w_hit_m ? FWD_MEM : w_hit_w ? FWD_WB : FWD_RF;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control, memory-wait FSM with timeout, perf counters
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      Rs1E,
    input  logic [4:0]      Rs2E,
    input  logic [4:0]      RdE,
    input  logic            ResultSrcE0,
    input  logic            PCSrcE,
    input  logic [4:0]      RdM,
    input  logic            RegWriteM,
    input  logic [4:0]      RdW,
    input  logic            RegWriteW,
    input  logic            MemReqM,
    input  logic            MemReadyM,
    input  logic            ClrCnt,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            StallM,
    output logic            FlushD,
    output logic            FlushE,
    output logic            FlushW,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            MemErr,
    output logic [CNTW-1:0] StallCnt,
    output logic [CNTW-1:0] FlushCnt
);
    localparam int WW = $clog2(TIMEOUT + 1);
    state_t         r_state;
    logic [WW-1:0]  r_wait;
    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_flush_cnt;
    logic           w_lw;
    logic           w_mem_stall;
    forward_sel u_fwd_a (
        .RsE(Rs1E), .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .ForwardE(ForwardAE)
    );
    forward_sel u_fwd_b (
        .RsE(Rs2E), .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .ForwardE(ForwardBE)
    );
    // A frozen pipeline must not flush: the taken branch stays in D/E and acts after release
    always_comb begin
        w_lw        = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        w_mem_stall = (r_state == ERROR) || ((r_state == WAIT) && !MemReadyM) ||
                      ((r_state == RUN) && MemReqM && !MemReadyM);
        StallF      = w_mem_stall || w_lw;
        StallD      = w_mem_stall || w_lw;
        StallE      = w_mem_stall;
        StallM      = w_mem_stall;
        FlushW      = w_mem_stall;
        FlushD      = !w_mem_stall && PCSrcE;
        FlushE      = !w_mem_stall && (w_lw || PCSrcE);
    end
    assign MemErr   = (r_state == ERROR);
    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_wait      <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state == RUN) && MemReqM && !MemReadyM) begin
                r_state <= WAIT;
                r_wait  <= '0;
            end else if (r_state == WAIT) begin
                if (MemReadyM)
                    r_state <= RUN;
                else if (r_wait == WW'(TIMEOUT - 1))
                    r_state <= ERROR;
                else
                    r_wait <= r_wait + WW'(1);
            end
            if (ClrCnt)
                r_stall_cnt <= '0;
            else if (StallF && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            if (ClrCnt)
                r_flush_cnt <= '0;
            else if (FlushD && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNTW'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plan scenarios plus random stimulus against a behavioural model
module tb_pipeline_hazard_ctrl;
    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic rese, pcsrc, rwm, rww, req, rdy, clr;
    logic stf, std, ste, stm, fld, fle, flw, merr;
    logic [1:0] fa, fb;
    logic [CW-1:0] scnt, fcnt;
    int n_cmp = 0;
    int n_err = 0;
    bit m_err, m_wait;
    int m_wcnt, m_sc, m_fc;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNTW(CW)) dut (
        .clk(clk), .reset(rst_n),
        .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e), .RdE(rde),
        .ResultSrcE0(rese), .PCSrcE(pcsrc), .RdM(rdm), .RegWriteM(rwm),
        .RdW(rdw), .RegWriteW(rww), .MemReqM(req), .MemReadyM(rdy), .ClrCnt(clr),
        .StallF(stf), .StallD(std), .StallE(ste), .StallM(stm),
        .FlushD(fld), .FlushE(fle), .FlushW(flw),
        .ForwardAE(fa), .ForwardBE(fb), .MemErr(merr), .StallCnt(scnt), .FlushCnt(fcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs);
        if (rwm && rdm != 0 && rdm == rs) return 2;
        if (rww && rdw != 0 && rdw == rs) return 1;
        return 0;
    endfunction

    task automatic idle();
        {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
        {rese, pcsrc, rwm, rww, req, clr} = '0;
        rdy   = 1'b1;
        rst_n = 1'b1;
    endtask

    // check outputs for the current inputs, advance the model, move to the next negedge
    task automatic step();
        bit lw, ms, sf, fd;
        #1;
        if (!rst_n) begin
            m_err = 0; m_wait = 0; m_wcnt = 0; m_sc = 0; m_fc = 0;
        end
        lw = rese && rde != 0 && (rde == rs1d || rde == rs2d);
        ms = m_err || (m_wait ? !rdy : (req && !rdy));
        sf = ms || lw;
        fd = !ms && pcsrc;
        chk("ForwardAE", 32'(fa), fwd(rs1e));
        chk("ForwardBE", 32'(fb), fwd(rs2e));
        chk("StallF", 32'(stf), 32'(sf));
        chk("StallD", 32'(std), 32'(sf));
        chk("StallE", 32'(ste), 32'(ms));
        chk("StallM", 32'(stm), 32'(ms));
        chk("FlushW", 32'(flw), 32'(ms));
        chk("FlushD", 32'(fld), 32'(fd));
        chk("FlushE", 32'(fle), 32'(!ms && (lw || pcsrc)));
        chk("MemErr", 32'(merr), 32'(m_err));
        chk("StallCnt", 32'(scnt), 32'(m_sc));
        chk("FlushCnt", 32'(fcnt), 32'(m_fc));
        if (rst_n) begin
            if (m_wait) begin
                if (rdy) m_wait = 0;
                else begin
                    m_wcnt++;
                    if (m_wcnt == TO) begin m_err = 1; m_wait = 0; end
                end
            end else if (!m_err && req && !rdy) begin
                m_wait = 1;
                m_wcnt = 0;
            end
            m_sc = clr ? 0 : (sf && m_sc < CMAX) ? m_sc + 1 : m_sc;
            m_fc = clr ? 0 : (fd && m_fc < CMAX) ? m_fc + 1 : m_fc;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        rs1e = 5; rdm = 5; rwm = 1; rdw = 5; rww = 1;
        #1 chk("fwd_mem_prio", 32'(fa), 2);
        step();
        rdm = 0;
        #1 chk("fwd_wb_rd0", 32'(fa), 1);
        step();
        idle(); rese = 1; rde = 7; rs2d = 7;
        step();
        idle();
        chk("lw_cnt", 32'(scnt), 1);
        pcsrc = 1;
        step();
        idle();
        chk("br_cnt", 32'(fcnt), 1);
        req = 1; rdy = 0; pcsrc = 1;
        repeat (3) begin
            #1 chk("wait_flushD", 32'(fld), 0);
            step();
        end
        rdy = 1;
        #1 chk("release_flushD", 32'(fld), 1);
        step();
        idle();
        step();
        req = 1; rdy = 0;
        repeat (5) step();
        chk("timeout_err", 32'(merr), 1);
        rdy = 1;
        step();
        chk("err_sticky", 32'(merr), 1);
        rst_n = 1'b0;
        #1 chk("err_reset", 32'(merr), 0);
        step();
        idle(); rese = 1; rde = 3; rs1d = 3;
        repeat (20) step();
        chk("sat_stall", 32'(scnt), 15);
        clr = 1;
        step();
        chk("clr_prio", 32'(scnt), 0);
        for (int i = 0; i < 3000; i++) begin
            rs1d  = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
            rs1e  = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
            rde   = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
            rdw   = 5'($urandom_range(0, 3));
            rese  = 1'($urandom); pcsrc = ($urandom_range(0, 3) == 0);
            rwm   = 1'($urandom); rww = 1'($urandom);
            req   = ($urandom_range(0, 2) == 0); rdy = 1'($urandom);
            clr   = ($urandom_range(0, 29) == 0);
            rst_n = ($urandom_range(0, 59) != 0);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
